// File: rtl/load_store_unit.sv
// load_store_unit: multicycle load/store sequencer for a 64-bit data memory.
// Loads read one doubleword and then sign- or zero-extend the addressed lanes.
// sd writes the whole doubleword directly. sb/sh/sw use read-modify-write.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, a misaligned
// access completes with err=1. When it is not defined, the low address bits
// are forced to 0 and the access proceeds aligned.
module load_store_unit #(
    parameter int XLEN    = 64,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            is_store,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wr,
    output logic [XLEN-1:0] load_data,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int LANES = XLEN / 8;

    // The sequencer assumes a single-cycle registered memory read and 8 byte lanes.
    generate
        if (MEM_LAT != 1) begin : g_bad_mem_lat
            $error("load_store_unit: only MEM_LAT == 1 is supported");
        end
        if (XLEN != 64) begin : g_bad_xlen
            $error("load_store_unit: only XLEN == 64 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_is_store;
    logic [2:0]        r_func3;
    logic [2:0]        r_k;
    logic              r_err;
    logic [XLEN-1:0]   r_sdata;
    logic [XLEN-1:0]   r_mem_addr;
    logic [XLEN-1:0]   r_wdata;     // line buffer: merged doubleword or sd data
    logic [XLEN-1:0]   r_load_data;
    logic              r_mem_wr;

    logic [2:0]        w_align_bits;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_fault;
    logic              w_is_sd;
    logic [2:0]        w_k;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_extract;
    logic [LANES-1:0]  w_lane_base;
    logic [LANES-1:0]  w_byte_en;
    logic [XLEN-1:0]   w_bit_mask;
    logic [XLEN-1:0]   w_sdata_sh;
    logic [XLEN-1:0]   w_merged;

    // Classify the incoming request: illegal encodings, alignment, and byte offset.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_align_bits = 3'b000;
        w_illegal    = 1'b0;
        w_misalign   = 1'b0;
        w_k          = addr[2:0];
        case (func3[1:0])
            2'b00:   w_align_bits = 3'b000;
            2'b01:   w_align_bits = 3'b001;
            2'b10:   w_align_bits = 3'b011;
            default: w_align_bits = 3'b111;
        endcase
        w_illegal = is_store ? func3[2] : (func3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = |(addr[2:0] & w_align_bits);
`else
        w_misalign = 1'b0;
        w_k        = addr[2:0] & ~w_align_bits;
`endif
        w_fault = w_illegal | w_misalign;
        w_is_sd = is_store & (func3 == 3'b011);
    end

    // Next-state logic for the sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_fault)      w_next = S_FIN;
                    else if (w_is_sd) w_next = S_WR;
                    else              w_next = S_RD;
                end
            end
            S_RD:    w_next = S_CAP;
            S_CAP:   w_next = r_is_store ? S_WR : S_FIN;
            S_WR:    w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Load extraction: shift the addressed lane down, then extend according to func3.
    always_comb begin
        w_shifted = mem_rdata >> {r_k, 3'b000};
        w_extract = w_shifted;
        case (r_func3)
            3'b000:  w_extract = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_extract = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_extract = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_extract = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
            3'b101:  w_extract = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
            3'b110:  w_extract = {{(XLEN-32){1'b0}},          w_shifted[31:0]};
            default: w_extract = w_shifted;
        endcase
    end

    // Store merge: replace only the addressed byte lanes of the doubleword that was read.
    always_comb begin
        case (r_func3[1:0])
            2'b00:   w_lane_base = LANES'(8'h01);
            2'b01:   w_lane_base = LANES'(8'h03);
            2'b10:   w_lane_base = LANES'(8'h0F);
            default: w_lane_base = LANES'(8'hFF);
        endcase
        w_byte_en  = w_lane_base << r_k;
        w_bit_mask = '0;
        for (int j = 0; j < LANES; j++) begin
            w_bit_mask[8*j +: 8] = {8{w_byte_en[j]}};
        end
        w_sdata_sh = r_sdata << {r_k, 3'b000};
        w_merged   = (mem_rdata & ~w_bit_mask) | (w_sdata_sh & w_bit_mask);
    end

    // Datapath registers: request capture, line buffer, load result, write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_store  <= 1'b0;
            r_func3     <= 3'b000;
            r_k         <= 3'b000;
            r_err       <= 1'b0;
            r_sdata     <= '0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
            r_load_data <= '0;
            r_mem_wr    <= 1'b0;
        end else begin
            r_mem_wr <= (w_next == S_WR);
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_is_store <= is_store;
                        r_func3    <= func3;
                        r_k        <= w_k;
                        r_err      <= w_fault;
                        r_sdata    <= store_data;
                        if (!w_fault) begin
                            r_mem_addr <= {addr[XLEN-1:3], 3'b000};
                            if (w_is_sd) r_wdata <= store_data;
                        end
                    end
                end
                S_CAP: begin
                    if (r_is_store) r_wdata     <= w_merged;
                    else            r_load_data <= w_extract;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_wdata;
    assign load_data = r_load_data;
    // NOTE: the registered strobe is also gated by reset, so a reset in the WR cycle lands no write.
    assign mem_wr    = r_mem_wr & ~reset;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign err       = done & r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a registered-read doubleword memory model.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        is_store;
    logic [2:0]  func3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [63:0] mem_rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] load_data;
    logic        busy;
    logic        done;
    logic        err;

    int vectors    = 0;
    int miscompares = 0;

    // Per-operation observations.
    int          op_lat;
    int          op_wr_cnt;
    int          op_wr_at;
    int          op_dones;
    logic [63:0] op_wr_data;
    logic        op_err;
    logic [63:0] op_ld;

    // Memory model: preload port plus DUT port.
    logic [63:0] mem [0:127];
    logic        tb_we;
    logic [6:0]  tb_idx;
    logic [63:0] tb_wdata;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .is_store   (is_store),
        .func3      (func3),
        .addr       (addr),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .load_data  (load_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read, write on strobe.
    always @(posedge clk) begin
        if (mem_wr)     mem[mem_addr[9:3]] <= mem_wdata;
        else if (tb_we) mem[tb_idx]        <= tb_wdata;
        mem_rdata <= mem[mem_addr[9:3]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [63:0] data);
        tb_we    = 1'b1;
        tb_idx   = idx;
        tb_wdata = data;
        @(posedge clk);
        #1 tb_we = 1'b0;
        @(negedge clk);
    endtask

    // Issue one request at the current negedge and observe 8 following cycles.
    task automatic run_op(input logic st, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] sd);
        op_lat     = -1;
        op_wr_cnt  = 0;
        op_wr_at   = -1;
        op_dones   = 0;
        op_wr_data = '0;
        op_err     = 1'bx;
        op_ld      = 'x;
        req        = 1'b1;
        is_store   = st;
        func3      = f3;
        addr       = a;
        store_data = sd;
        @(posedge clk);
        #1 req = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_wr) begin
                op_wr_cnt++;
                op_wr_at   = n;
                op_wr_data = mem_wdata;
            end
            if (done) begin
                op_dones++;
                if (op_lat < 0) begin
                    op_lat = n;
                    op_err = err;
                    op_ld  = load_data;
                end
            end
        end
    endtask

    initial begin
        logic [63:0] ld_prev;
        reset      = 1'b1;
        req        = 1'b0;
        is_store   = 1'b0;
        func3      = 3'b000;
        addr       = '0;
        store_data = '0;
        tb_we      = 1'b0;
        tb_idx     = '0;
        tb_wdata   = '0;

        @(negedge clk);
        preload(7'd2, 64'h0000_0000_8000_00F0);   // 0x10
        preload(7'd4, 64'h1122_3344_5566_7788);   // 0x20
        preload(7'd6, 64'h0123_4567_89AB_CDEF);   // 0x30
        preload(7'd8, 64'h0);                     // 0x40

        // Reset state
        check("rst_busy",  64'(busy),   64'd0);
        check("rst_done",  64'(done),   64'd0);
        check("rst_err",   64'(err),    64'd0);
        check("rst_wr",    64'(mem_wr), 64'd0);
        check("rst_addr",  mem_addr,    64'd0);
        check("rst_wdata", mem_wdata,   64'd0);
        check("rst_ld",    load_data,   64'd0);
        reset = 1'b0;
        @(negedge clk);

        // lb 0x10: sign extension
        run_op(1'b0, 3'b000, 64'h10, 64'h0);
        check("lb_lat",  64'(op_lat),    64'd3);
        check("lb_data", op_ld,          64'hFFFF_FFFF_FFFF_FFF0);
        check("lb_err",  64'(op_err),    64'd0);
        check("lb_wr",   64'(op_wr_cnt), 64'd0);
        check("lb_addr", mem_addr,       64'h10);

        // lbu 0x10
        run_op(1'b0, 3'b100, 64'h10, 64'h0);
        check("lbu_data", op_ld, 64'h0000_0000_0000_00F0);

        // lh 0x12, lw 0x10, lwu 0x10, ld 0x10
        run_op(1'b0, 3'b001, 64'h12, 64'h0);
        check("lh_data", op_ld, 64'hFFFF_FFFF_FFFF_8000);
        run_op(1'b0, 3'b010, 64'h10, 64'h0);
        check("lw_data", op_ld, 64'hFFFF_FFFF_8000_00F0);
        run_op(1'b0, 3'b110, 64'h10, 64'h0);
        check("lwu_data", op_ld, 64'h0000_0000_8000_00F0);
        run_op(1'b0, 3'b011, 64'h10, 64'h0);
        check("ld_data", op_ld, 64'h0000_0000_8000_00F0);
        check("ld_lat",  64'(op_lat), 64'd3);

        // sh 0x22: read-modify-write
        run_op(1'b1, 3'b001, 64'h22, 64'h0000_0000_0000_ABCD);
        check("sh_wr_cnt", 64'(op_wr_cnt), 64'd1);
        check("sh_wr_at",  64'(op_wr_at),  64'd3);
        check("sh_wdata",  op_wr_data,     64'h1122_3344_ABCD_7788);
        check("sh_lat",    64'(op_lat),    64'd4);
        check("sh_err",    64'(op_err),    64'd0);
        check("sh_mem",    mem[4],         64'h1122_3344_ABCD_7788);
        check("sh_ld_keep", load_data,     64'h0000_0000_8000_00F0);

        // sd 0x40: no read cycle
        run_op(1'b1, 3'b011, 64'h40, 64'hDEAD_BEEF_0000_0001);
        check("sd_wr_cnt", 64'(op_wr_cnt), 64'd1);
        check("sd_wr_at",  64'(op_wr_at),  64'd1);
        check("sd_wdata",  op_wr_data,     64'hDEAD_BEEF_0000_0001);
        check("sd_lat",    64'(op_lat),    64'd2);
        check("sd_err",    64'(op_err),    64'd0);
        check("sd_mem",    mem[8],         64'hDEAD_BEEF_0000_0001);

        // Misaligned lw at 0x13
        ld_prev = load_data;
        run_op(1'b0, 3'b010, 64'h13, 64'h0);
        check("mis_wr_cnt", 64'(op_wr_cnt), 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lat",  64'(op_lat), 64'd1);
        check("mis_err",  64'(op_err), 64'd1);
        check("mis_keep", load_data,   ld_prev);
`else
        check("mis_lat",  64'(op_lat), 64'd3);
        check("mis_err",  64'(op_err), 64'd0);
        check("mis_data", op_ld,       64'hFFFF_FFFF_8000_00F0);
        check("mis_addr", mem_addr,    64'h10);
`endif

        // Illegal store func3 100 and illegal load func3 111
        ld_prev = load_data;
        run_op(1'b1, 3'b100, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ill_st_lat",  64'(op_lat),    64'd1);
        check("ill_st_err",  64'(op_err),    64'd1);
        check("ill_st_wr",   64'(op_wr_cnt), 64'd0);
        check("ill_st_mem",  mem[4],         64'h1122_3344_ABCD_7788);
        run_op(1'b0, 3'b111, 64'h10, 64'h0);
        check("ill_ld_lat",  64'(op_lat),    64'd1);
        check("ill_ld_err",  64'(op_err),    64'd1);
        check("ill_ld_keep", load_data,      ld_prev);

        // req held while busy: only the first request (lb 0x10) is accepted
        op_dones  = 0;
        op_wr_cnt = 0;
        req        = 1'b1;
        is_store   = 1'b0;
        func3      = 3'b000;
        addr       = 64'h10;
        store_data = 64'h0;
        @(posedge clk);
        #1;
        is_store   = 1'b1;
        func3      = 3'b011;
        addr       = 64'h40;
        store_data = 64'h5555_5555_5555_5555;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n >= 2) req = 1'b0;
            if (mem_wr) op_wr_cnt++;
            if (done)   op_dones++;
        end
        check("busy_dones", 64'(op_dones),  64'd1);
        check("busy_wr",    64'(op_wr_cnt), 64'd0);
        check("busy_ld",    load_data,      64'hFFFF_FFFF_FFFF_FFF0);
        check("busy_mem",   mem[8],         64'hDEAD_BEEF_0000_0001);

        // Reset in the WR cycle of sw 0x34
        req        = 1'b1;
        is_store   = 1'b1;
        func3      = 3'b010;
        addr       = 64'h34;
        store_data = 64'h0000_0000_CAFE_F00D;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rmw_in_wr",  64'(mem_wr), 64'd1);
        check("rmw_wdata",  mem_wdata,   64'hCAFE_F00D_89AB_CDEF);
        reset = 1'b1;
        @(negedge clk);
        check("rmo_wr",    64'(mem_wr), 64'd0);
        check("rmo_busy",  64'(busy),   64'd0);
        check("rmo_done",  64'(done),   64'd0);
        check("rmo_err",   64'(err),    64'd0);
        check("rmo_addr",  mem_addr,    64'd0);
        check("rmo_wdata", mem_wdata,   64'd0);
        check("rmo_ld",    load_data,   64'd0);
        check("rmo_mem",   mem[6],      64'h0123_4567_89AB_CDEF);
        reset = 1'b0;
        @(negedge clk);

        // lb after reset works normally
        run_op(1'b0, 3'b000, 64'h30, 64'h0);
        check("post_lat",  64'(op_lat), 64'd3);
        check("post_data", op_ld,       64'hFFFF_FFFF_FFFF_FFEF);
        check("post_err",  64'(op_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
